imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have one clock, `clk`, and all state SHALL update on its rising edge.
REQ-002 Reset SHALL be synchronous and active-high, named `reset`.
REQ-003 Parameter `DEPTH`, default 256: number of 32-bit instruction words; SHALL be a power of two.
REQ-004 Parameter `NOP`, default 32'h00000013: instruction returned on error.
REQ-005 The block SHALL provide these ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  fetch request present
- req_ready  out  1  block can accept a request
- req_pc  in  32  fetch byte address
- resp_valid  out  1  response at FIFO head
- resp_ready  in  1  consumer takes the response
- resp_instr  out  32  fetched instruction
- resp_pc  out  32  address the response belongs to
- resp_err  out  1  misaligned or out-of-range fetch
- flush  in  1  discard all pending responses
- wr_en  in  1  preload write strobe
- wr_addr  in  32  preload byte address
- wr_data  in  32  preload word

Function
REQ-006 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-007 The word index SHALL be req_pc[log2(DEPTH)+1:2].
REQ-008 Response storage SHALL be a 2-entry FIFO holding {instr, pc, err}, with count in 0..2.
REQ-009 req_ready SHALL equal (count < 2) && !flush, with no combinational path from resp_ready.
REQ-010 Latency SHALL be one cycle: a request accepted at edge k SHALL have its entry written at edge k, and resp_valid SHALL be high in the cycle following edge k if the FIFO was empty.
REQ-011 resp_valid SHALL equal (count != 0); resp_instr, resp_pc and resp_err SHALL always reflect the head entry.
REQ-012 Pop SHALL occur when resp_valid && resp_ready.
- Push and pop in the same edge SHALL leave count unchanged.
- Pop SHALL preserve FIFO order.
REQ-013 If req_pc[1:0] != 0, the entry SHALL have err=1 and instr=NOP.
REQ-014 If req_pc[31:2] >= DEPTH, the entry SHALL have err=1 and instr=NOP.
REQ-015 Otherwise the entry SHALL have err=0 and instr=mem[index].
REQ-016 resp_pc SHALL equal req_pc exactly, including the low bits.
REQ-017 When wr_en is high, mem[wr_addr[log2(DEPTH)+1:2]] SHALL be written at the edge.
- Out-of-range wr_addr SHALL be ignored.
REQ-018 A write and a fetch to the same word in the same edge SHALL return the old (pre-write) word.
REQ-019 flush SHALL set count to 0 at the edge, discarding the FIFO contents.
- No request SHALL be accepted during flush.
- A pop during flush SHALL have no effect beyond the clear.
REQ-020 Holding resp_valid high with resp_ready low SHALL keep all head outputs stable.

Reset
REQ-021 On reset, count SHALL be cleared to 0, giving resp_valid=0 and req_ready=1 in the next cycle.
REQ-022 On reset, resp_instr and resp_pc SHALL read 0 and resp_err SHALL read 0.
REQ-023 Reset SHALL have priority over flush, req_valid and wr_en.
- Memory contents SHALL NOT be cleared by reset.
- wr_en during reset SHALL be ignored.
REQ-024 Reset mid-operation SHALL drop all pending responses, with no response emitted afterwards for them.

Verification
REQ-025 Preload: write mem[0..3]=11111111/22222222/33333333/44444444, then issue requests to pc 0,4,8,12 with resp_ready=1 -> responses arrive in order, one per cycle, err=0, pc matching.
REQ-026 Backpressure: resp_ready=0 and two requests to pc 0 and 4 -> count=2 and req_ready=0, head stays 11111111; set resp_ready=1 -> 11111111 then 22222222.
REQ-027 Errors: request pc 0x6 -> err=1, instr=00000013, resp_pc=00000006; request pc=4*DEPTH -> err=1, instr=00000013.
REQ-028 Flush: two responses pending, then assert flush for one cycle -> next cycle resp_valid=0, req_ready=1, and no stale data appears.
REQ-029 Same-word write and fetch to pc 8 with wr_data=AAAAAAAA -> response is 33333333; a following fetch to pc 8 returns AAAAAAAA.
REQ-030 Reset with one response pending -> next cycle resp_valid=0, resp_pc=0; a refetch of pc 0 returns 11111111.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction memory with one-cycle fetch latency and a 2-entry response FIFO.
// Fetches outside the array or with a misaligned pc return NOP with err set.
module imem_responder #(
    parameter int          DEPTH = 256,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_instr,
    output logic [31:0] resp_pc,
    output logic        resp_err,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
);
    // DEPTH must be a power of two and at least 2.
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } entry_t;

    // Handshake: a request transfers on an edge where req_valid && req_ready;
    // a response transfers on an edge where resp_valid && resp_ready.
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          rd_oob;
    logic          rd_misaligned;
    logic          wr_oob;
    entry_t        new_entry;
    entry_t        slot0;
    entry_t        slot1;
    logic [1:0]    count;
    logic          push;
    logic          pop;

    assign rd_idx        = req_pc[AW+1:2];
    assign wr_idx        = wr_addr[AW+1:2];
    assign rd_oob        = (req_pc >> (AW + 2)) != 32'd0;
    assign wr_oob        = (wr_addr >> (AW + 2)) != 32'd0;
    assign rd_misaligned = req_pc[1:0] != 2'b00;

    always_comb begin
        new_entry.pc = req_pc;
        if (rd_oob || rd_misaligned) begin
            new_entry.instr = NOP;
            new_entry.err   = 1'b1;
        end else begin
            new_entry.instr = mem[rd_idx];
            new_entry.err   = 1'b0;
        end
    end

    // req_ready depends only on stored count and flush, never on resp_ready.
    assign req_ready  = (count != 2'd2) && !flush;
    assign push       = req_valid && req_ready;
    assign pop        = (count != 2'd0) && resp_ready;

    assign resp_valid = count != 2'd0;
    assign resp_instr = slot0.instr;
    assign resp_pc    = slot0.pc;
    assign resp_err   = slot0.err;

    // Array read above sees the pre-write word, so a same-edge write and fetch
    // to one index returns the old contents.
    always_ff @(posedge clk) begin
        if (!reset && wr_en && !wr_oob) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= new_entry;
                    end else begin
                        slot1 <= new_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= new_entry;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= new_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a vector table of one-edge steps with
// post-edge expectations, then hand sequences for flush timing and reset.
module tb_imem_responder;
  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic [31:0] resp_pc;
  logic        resp_err;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  imem_responder #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_instr(resp_instr), .resp_pc(resp_pc), .resp_err(resp_err),
    .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        rv;
    logic [31:0] pc;
    logic        rr;
    logic        fl;
    logic        e_valid;
    logic        e_ready;
    logic        chk_data;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [31:0] wa, logic [31:0] wd,
                              logic rv, logic [31:0] pc, logic rr, logic fl,
                              logic ev, logic er, logic cd,
                              logic [31:0] ei, logic [31:0] ep, logic ee);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.rv = rv; v.pc = pc; v.rr = rr; v.fl = fl;
    v.e_valid = ev; v.e_ready = er; v.chk_data = cd;
    v.e_instr = ei; v.e_pc = ep; v.e_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    req_valid = 1'b0;
    req_pc    = 32'd0;
    flush     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = 32'd0;
    wr_data   = 32'd0;
  endtask

  // One edge with the vector's inputs, then inputs go idle and outputs are compared.
  task automatic apply(input vec_t v, input int idx);
    string tag;
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    req_valid = v.rv; req_pc = v.pc; resp_ready = v.rr; flush = v.fl;
    @(posedge clk);
    #1;
    drive_idle();
    #1;
    tag = $sformatf("vec%0d", idx);
    check({tag, ".resp_valid"}, {31'd0, resp_valid}, {31'd0, v.e_valid});
    check({tag, ".req_ready"}, {31'd0, req_ready}, {31'd0, v.e_ready});
    if (v.chk_data) begin
      check({tag, ".resp_instr"}, resp_instr, v.e_instr);
      check({tag, ".resp_pc"}, resp_pc, v.e_pc);
      check({tag, ".resp_err"}, {31'd0, resp_err}, {31'd0, v.e_err});
    end
  endtask

  initial begin
    vec_t v;
    drive_idle();
    resp_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.resp_instr", resp_instr, 32'd0);
    check("rst.resp_pc", resp_pc, 32'd0);
    check("rst.resp_err", {31'd0, resp_err}, 32'd0);
    reset = 1'b0;

    //             we wa            wd            rv pc            rr fl  ev er cd instr         pc            err
    // preload
    vecs.push_back(mk(1, 32'h0,      32'h11111111, 0, 32'h0,       0, 0,  0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'h4,      32'h22222222, 0, 32'h0,       0, 0,  0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'h8,      32'h33333333, 0, 32'h0,       0, 0,  0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hC,      32'h44444444, 0, 32'h0,       0, 0,  0, 1, 0, 32'h0,        32'h0,        0));
    // streaming fetch, one response per cycle
    vecs.push_back(mk(0, 32'h0,      32'h0,        1, 32'h0,       1, 0,  1, 1, 1, 32'h11111111, 32'h0,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        1, 32'h4,       1, 0,  1, 1, 1, 32'h22222222, 32'h4,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        1, 32'h8,       1, 0,  1, 1, 1, 32'h33333333, 32'h8,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        1, 32'hC,       1, 0,  1, 1, 1, 32'h44444444, 32'hC,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        0, 32'h0,       1, 0,  0, 1, 0, 32'h0,        32'h0,        0));
    // backpressure: fill to 2, hold, drain in order
    vecs.push_back(mk(0, 32'h0,      32'h0,        1, 32'h0,       0, 0,  1, 1, 1, 32'h11111111, 32'h0,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        1, 32'h4,       0, 0,  1, 0, 1, 32'h11111111, 32'h0,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        0, 32'h0,       0, 0,  1, 0, 1, 32'h11111111, 32'h0,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        0, 32'h0,       1, 0,  1, 1, 1, 32'h22222222, 32'h4,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        0, 32'h0,       1, 0,  0, 1, 0, 32'h0,        32'h0,        0));
    // misaligned and out-of-range fetches
    vecs.push_back(mk(0, 32'h0,      32'h0,        1, 32'h6,       0, 0,  1, 1, 1, NOP,          32'h6,        1));
    vecs.push_back(mk(0, 32'h0,      32'h0,        0, 32'h0,       1, 0,  0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        1, 32'h400,     0, 0,  1, 1, 1, NOP,          32'h400,      1));
    vecs.push_back(mk(0, 32'h0,      32'h0,        0, 32'h0,       1, 0,  0, 1, 0, 32'h0,        32'h0,        0));
    // flush with two pending and a request offered during flush
    vecs.push_back(mk(0, 32'h0,      32'h0,        1, 32'h0,       0, 0,  1, 1, 1, 32'h11111111, 32'h0,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        1, 32'h4,       0, 0,  1, 0, 1, 32'h11111111, 32'h0,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        1, 32'h8,       1, 1,  0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        0, 32'h0,       0, 0,  0, 1, 0, 32'h0,        32'h0,        0));
    // same-word write and fetch returns the old word
    vecs.push_back(mk(1, 32'h8,      32'hAAAAAAAA, 1, 32'h8,       0, 0,  1, 1, 1, 32'h33333333, 32'h8,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        1, 32'h8,       1, 0,  1, 1, 1, 32'hAAAAAAAA, 32'h8,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        0, 32'h0,       1, 0,  0, 1, 0, 32'h0,        32'h0,        0));
    // out-of-range write must not alias onto word 0
    vecs.push_back(mk(1, 32'h400,    32'hDEADBEEF, 0, 32'h0,       0, 0,  0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        1, 32'h0,       0, 0,  1, 1, 1, 32'h11111111, 32'h0,        0));
    vecs.push_back(mk(0, 32'h0,      32'h0,        0, 32'h0,       1, 0,  0, 1, 0, 32'h0,        32'h0,        0));

    foreach (vecs[i]) apply(vecs[i], i);

    // req_ready drops combinationally while flush is high
    resp_ready = 1'b0;
    flush = 1'b1;
    #1;
    check("flush.req_ready_comb", {31'd0, req_ready}, 32'd0);
    flush = 1'b0;
    #1;
    check("noflush.req_ready_comb", {31'd0, req_ready}, 32'd1);

    // reset with a response pending; flush, request and write are all ignored
    v = mk(0, 32'h0, 32'h0, 1, 32'h4, 0, 0, 1, 1, 1, 32'h22222222, 32'h4, 0);
    apply(v, 100);
    reset = 1'b1;
    req_valid = 1'b1; req_pc = 32'h8;
    wr_en = 1'b1; wr_addr = 32'h0; wr_data = 32'h00000BAD;
    flush = 1'b1;
    @(posedge clk);
    #1;
    drive_idle();
    reset = 1'b0;
    #1;
    check("rst2.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst2.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst2.resp_pc", resp_pc, 32'd0);
    check("rst2.resp_instr", resp_instr, 32'd0);
    check("rst2.resp_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk);
    #1;
    check("rst2.no_stale", {31'd0, resp_valid}, 32'd0);

    // memory survives reset and the write during reset was dropped
    v = mk(0, 32'h0, 32'h0, 1, 32'h0, 0, 0, 1, 1, 1, 32'h11111111, 32'h0, 0);
    apply(v, 101);
    v = mk(0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 0, 1, 0, 32'h0, 32'h0, 0);
    apply(v, 102);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
